// File: rtl/threaded_regfile_wb.sv
// Per-thread register file with write-back sink and two registered read ports.
// Read latency 1 cycle; writes land on the edge they are presented (same-edge bypass to reads).
// No backpressure: writes and reads issued before init_done are dropped / return zero.
module threaded_regfile_wb #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_write_back_flag,
  input  logic [REG_INDEX_BITS-1:0]    wb_reg_index,
  input  logic [THREAD_INDEX_BITS-1:0] wb_thread_index,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         rd_en,
  input  logic [THREAD_INDEX_BITS-1:0] rd_thread_index,
  input  logic [REG_INDEX_BITS-1:0]    rs1_index,
  input  logic [REG_INDEX_BITS-1:0]    rs2_index,
  output logic [DATA_WIDTH-1:0]        rs1_data,
  output logic [DATA_WIDTH-1:0]        rs2_data,
  output logic                         init_done
);

  localparam int ADDR_BITS = THREAD_INDEX_BITS + REG_INDEX_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   sweep_cnt;
  logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];

  logic                   wr_ok;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [ADDR_BITS-1:0]   rd_addr1;
  logic [ADDR_BITS-1:0]   rd_addr2;
  logic [DATA_WIDTH-1:0]  rs1_nxt;
  logic [DATA_WIDTH-1:0]  rs2_nxt;

  // Register 0 is hardwired to zero, so writes to it never reach storage.
  assign wr_ok    = (state == RUN) && wb_write_back_flag && (wb_reg_index != '0);
  assign wr_addr  = {wb_thread_index, wb_reg_index};
  assign rd_addr1 = {rd_thread_index, rs1_index};
  assign rd_addr2 = {rd_thread_index, rs2_index};

  // Sweep sequencing: count through every entry once, then enter RUN for good.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (&sweep_cnt) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Storage update: clear sweep during INIT, write-back traffic during RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[sweep_cnt] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wb_data;
      end
    end
  end

  // Read port 1 next value: zero for r0 or while clearing, bypass a same-edge matching write.
  always_comb begin
    rs1_nxt = '0;
    if ((state == RUN) && (rs1_index != '0)) begin
      rs1_nxt = (wr_ok && (wr_addr == rd_addr1)) ? wb_data : mem[rd_addr1];
    end
  end

  // Read port 2 next value: same rules as port 1.
  always_comb begin
    rs2_nxt = '0;
    if ((state == RUN) && (rs2_index != '0)) begin
      rs2_nxt = (wr_ok && (wr_addr == rd_addr2)) ? wb_data : mem[rd_addr2];
    end
  end

  // Registered read outputs; they hold whenever no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (rd_en) begin
      rs1_data <= rs1_nxt;
      rs2_data <= rs2_nxt;
    end
  end

endmodule

// File: doc/threaded_regfile_wb.md
# threaded_regfile_wb

Per-thread architectural register file and writeback sink for the multithreaded 5-stage pipeline. Consumes the write-back bundle registered by the MEM2/WB stage (flag, register index, thread index, data) and serves two registered read ports to decode. After every reset an internal sweep clears all thread/register entries before the file accepts traffic.

## Interface

- DATA_WIDTH, 64, register width in bits
- REG_INDEX_BITS, 5, architectural register index width (32 registers per thread)
- THREAD_INDEX_BITS, 3, hardware thread index width (8 threads)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- wb_write_back_flag  input  1  write enable from MEM2/WB stage
- wb_reg_index  input  REG_INDEX_BITS  destination register
- wb_thread_index  input  THREAD_INDEX_BITS  destination thread
- wb_data  input  DATA_WIDTH  write data
- rd_en  input  1  read request from decode
- rd_thread_index  input  THREAD_INDEX_BITS  thread for both read ports
- rs1_index  input  REG_INDEX_BITS  read port 1 register
- rs2_index  input  REG_INDEX_BITS  read port 2 register
- rs1_data  output  DATA_WIDTH  registered read data, port 1
- rs2_data  output  DATA_WIDTH  registered read data, port 2
- init_done  output  1  high once the clear sweep has finished

## Operation

- Storage: 2^(THREAD_INDEX_BITS+REG_INDEX_BITS) entries of DATA_WIDTH, addressed {thread, reg}.
- FSM states INIT, RUN. Reset (any cycle, any state) -> INIT, sweep counter = 0, init_done = 0, rs1_data = rs2_data = 0.
- INIT: each cycle writes 0 to entry[counter], counter += 1. On the edge writing the last entry (all ones) -> RUN and init_done <= 1. WB writes are dropped (not queued). rd_en loads 0 into both read outputs.
- RUN: on edge with wb_write_back_flag = 1 and wb_reg_index != 0, entry[{wb_thread_index, wb_reg_index}] <= wb_data. Writes to register 0 are discarded for every thread.
- Reads (RUN): on edge with rd_en = 1, rsN_data <= value of {rd_thread_index, rsN_index}. With rd_en = 0, rsN_data hold.
- Register 0 reads return 0 regardless of storage content.
- Write-first bypass: same-edge write with matching thread and register (index != 0) returns wb_data, not the stale entry. Thread index must match; same register in another thread does not bypass.
- Both ports may name the same register; both receive identical data.
- init_done stays 1 in RUN until the next reset.

## Timing

- Read latency 1 cycle: request sampled at edge N, data valid after edge N, held until the next rd_en edge.
- Write visible to a read sampled on the same edge (bypass) and all later edges.
- Sweep length exactly 2^(THREAD_INDEX_BITS+REG_INDEX_BITS) edges with reset low (256 at defaults); init_done is 1 after the 256th such edge.
- Reset asserted mid-sweep restarts the sweep from entry 0; reset in RUN re-clears all contents.
- Reset overrides writes and reads on the same edge.
- No backpressure to MEM2/WB: upstream must hold writes until init_done = 1; writes before that are lost by design.

## Test plan

- Release reset, count edges -> init_done rises after exactly 256 edges; rd_en of thread 7 r31 during sweep returns 0.
- RUN: write thread 3 r5 = 0x0000_0000_DEAD_BEEF, next cycle rd_en thread 3 rs1=5 rs2=5 -> both 0x...DEADBEEF; thread 2 r5 -> 0.
- Same edge write thread 1 r9 = 0x1234 and rd_en thread 1 rs1=9 -> rs1_data = 0x1234; same edge read thread 0 r9 -> 0.
- Write thread 4 r0 = 0xFFFF_FFFF_FFFF_FFFF -> subsequent read thread 4 r0 = 0.
- Write thread 6 r2 = 0xAA at sweep cycle 10 -> after init_done read thread 6 r2 = 0; rd_en low for 5 cycles -> outputs hold previous value.
- Fill thread 0 r1..r31 with index values, assert reset one cycle mid-RUN -> init_done drops to 0, returns after 256 edges, all reads return 0.
